work_receiver: RTL and testbench
================================

# work_receiver

Byte-stream front end that sits directly upstream of `work_handler`. It deframes 80-byte block-header work units arriving from the host link (one byte per strobe from the UART/AVR bridge) and assembles them into a 640-bit word. On each validated frame it presents that word as `work_data` and pulses `new_work` for one cycle. Malformed or stalled frames are dropped and flagged with `frame_error`.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker, accepted only in IDLE.
- `TIMEOUT_CYCLES`, default 50_000_000: maximum number of consecutive cycles without a byte inside a frame before abort. Legal range 1 to 2^32-1.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte, valid when `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per byte; may be high on consecutive cycles.
- `new_work`  out  1  one-cycle pulse; `work_data` is updated on the same cycle.
- `work_data`  out  640  last accepted header. Byte 0 is in [639:632]; byte 79 is in [7:0].
- `frame_error`  out  1  one-cycle pulse on timeout or checksum mismatch.
- `rx_busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, PAYLOAD, CHECK (present only with checksum enabled).
- IDLE:
  - Bytes not equal to `SYNC_BYTE` are discarded silently.
  - `SYNC_BYTE` moves the state to PAYLOAD and clears the byte counter (7 bits), the XOR accumulator and the timeout counter.
- PAYLOAD:
  - Each accepted byte shifts into a 640-bit shadow register (shift left by 8, insert at [7:0]), XORs into the accumulator, and increments the counter.
  - A byte equal to `SYNC_BYTE` is ordinary data here; there is no resynchronisation.
  - The 80th byte (counter value 79) moves the state to CHECK if checksum is enabled; otherwise the frame commits and the state returns to IDLE.
- CHECK:
  - The next byte is compared with the XOR of the 80 payload bytes. The sync byte is excluded from the XOR.
  - Match: commit. Mismatch: `frame_error` pulse.
  - Either way the state returns to IDLE.
- Commit: shadow register copied to `work_data`; `new_work` pulses. `work_data` is otherwise held stable.
- Timeout:
  - In PAYLOAD or CHECK, the timeout counter increments on every cycle with `rx_valid` low and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`: state returns to IDLE, `frame_error` pulses, partial data is discarded, `work_data` is unchanged.
- Reset (any time, including mid-frame): state IDLE; `work_data` = 0; `new_work`, `frame_error`, `rx_busy` = 0; all counters, the shadow register and the accumulator cleared.

## Timing
- Bytes are sampled on the rising edge of `clk` when `rx_valid` = 1.
- Commit latency: final byte (payload byte 80, or the checksum byte) sampled at edge N. `new_work` and the new `work_data` are visible after edge N+1 and stay for one cycle (pulse).
- `frame_error` is registered with the same one-cycle latency after the mismatching byte or the expiring cycle.
- If a byte arrives on the same cycle the timeout would expire, the byte wins: it is accepted and the timer clears.
- A sync byte arriving in the cycle after a commit is accepted; back-to-back frames need no idle gap.
- `rx_busy` rises the cycle after the sync byte is sampled and falls on the cycle `new_work` or `frame_error` pulses.
- `new_work` and `frame_error` are never high together.

## Configuration
- `WORK_RX_CHECKSUM_EN`
  - Defined: frame = sync + 80 payload + 1 XOR checksum byte; CHECK state present; mismatch raises `frame_error`.
  - Undefined: frame = sync + 80 payload; commit on the 80th byte; no CHECK state or accumulator; `frame_error` only on timeout.

## Test plan
- Reset: hold `rst` = 0 with `rx_valid` toggling. Required: all outputs 0, `work_data` = 0. Release; still all outputs 0.
- Good frame: 0xA5, then bytes 0x00..0x4F back-to-back, plus checksum 0x00 if enabled. Required: one `new_work` pulse one cycle after the last byte; `work_data[639:632]` = 0x00, `[7:0]` = 0x4F, `[15:8]` = 0x4E.
- Garbage then frame: 0x11, 0x22, 0x5A before the good frame above. Required: identical result, no `frame_error`.
- Timeout with `TIMEOUT_CYCLES` = 16: sync plus 10 bytes, then idle. Required: `frame_error` pulses exactly once, 16 idle cycles after the last byte; `rx_busy` falls; `work_data` keeps its previous value. A byte at idle cycle 16 instead extends the frame.
- Checksum (macro defined): good frame with checksum 0x01. Required: `frame_error` pulse, no `new_work`, `work_data` unchanged. The next frame with checksum 0x00 commits.
- Mid-frame reset: assert `rst` after 40 payload bytes, release, then send a full good frame. Required: a single `new_work` pulse; `work_data` equals the second frame only.

Source files
------------

// File: rtl/work_receiver.sv
`default_nettype none
// ============================================================================
// Module      : work_receiver
// Description : Deframes 80-byte work headers from the host byte link into a
//               640-bit word. Frames are SYNC_BYTE + 80 payload bytes, plus a
//               trailing XOR checksum byte when WORK_RX_CHECKSUM_EN is
//               defined. Stalled or corrupt frames are dropped and flagged on
//               frame_error.
// Revision    : 1.0 - initial release
// ============================================================================
module work_receiver #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         new_work,
  output logic [639:0] work_data,
  output logic         frame_error,
  output logic         rx_busy
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_PAYLOAD = 2'd1;
`ifdef WORK_RX_CHECKSUM_EN
  localparam logic [1:0] c_ST_CHECK   = 2'd2;
  // All 80 payload bytes live in the shadow before the checksum byte arrives.
  localparam int         c_SHADOW_W   = 640;
`else
  // The 80th byte goes straight to work_data, so only 79 need holding.
  localparam int         c_SHADOW_W   = 632;
`endif
  localparam logic [6:0]  c_LAST_IDX  = 7'd79;
  localparam logic [31:0] c_TMO_LAST  = TIMEOUT_CYCLES - 32'd1;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [6:0]            r_cnt;
  logic [31:0]           r_tmo;
  logic [c_SHADOW_W-1:0] r_shadow;
  logic [639:0]          r_work_data;
  logic [639:0]          w_commit_data;
  logic                  r_new_work;
  logic                  r_frame_error;
  logic                  w_sync_hit;
  logic                  w_expire;
  logic                  w_commit;
  logic                  w_abort;
`ifdef WORK_RX_CHECKSUM_EN
  logic [7:0]            r_xor;
`endif

  assign w_sync_hit = (r_state == c_ST_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
  // A byte on the expiring cycle wins, hence the !rx_valid term.
  assign w_expire   = (r_state != c_ST_IDLE) && !rx_valid && (r_tmo == c_TMO_LAST);

`ifdef WORK_RX_CHECKSUM_EN
  assign w_commit_data = r_shadow;
`else
  assign w_commit_data = {r_shadow, rx_data};
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and commit/abort decisions
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_sync_hit) begin
          w_state_next = c_ST_PAYLOAD;
        end
      end
      c_ST_PAYLOAD: begin
        if (w_expire) begin
          w_state_next = c_ST_IDLE;
          w_abort      = 1'b1;
        end else if (rx_valid && (r_cnt == c_LAST_IDX)) begin
`ifdef WORK_RX_CHECKSUM_EN
          w_state_next = c_ST_CHECK;
`else
          w_state_next = c_ST_IDLE;
          w_commit     = 1'b1;
`endif
        end
      end
`ifdef WORK_RX_CHECKSUM_EN
      c_ST_CHECK: begin
        if (w_expire) begin
          w_state_next = c_ST_IDLE;
          w_abort      = 1'b1;
        end else if (rx_valid) begin
          w_state_next = c_ST_IDLE;
          if (rx_data == r_xor) begin
            w_commit = 1'b1;
          end else begin
            w_abort  = 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_next = c_ST_IDLE;
      end
    endcase
  end

  // Busy whenever a frame is in flight
  always_comb begin
    rx_busy = (r_state != c_ST_IDLE);
  end

  // Byte counter, inactivity timer, shadow shift and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_tmo         <= '0;
      r_shadow      <= '0;
      r_work_data   <= '0;
      r_new_work    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_new_work    <= w_commit;
      r_frame_error <= w_abort;
      if (w_commit) begin
        r_work_data <= w_commit_data;
      end
      if (w_sync_hit) begin
        r_cnt <= '0;
        r_tmo <= '0;
      end else if (r_state != c_ST_IDLE) begin
        if (rx_valid) begin
          r_tmo <= '0;
        end else begin
          r_tmo <= r_tmo + 32'd1;
        end
        if (rx_valid && (r_state == c_ST_PAYLOAD)) begin
          r_cnt    <= r_cnt + 7'd1;
          r_shadow <= {r_shadow[c_SHADOW_W-9:0], rx_data};
        end
      end
    end
  end

`ifdef WORK_RX_CHECKSUM_EN
  // Running XOR of payload bytes; the sync byte never enters it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xor <= '0;
    end else if (w_sync_hit) begin
      r_xor <= '0;
    end else if (rx_valid && (r_state == c_ST_PAYLOAD)) begin
      r_xor <= r_xor ^ rx_data;
    end
  end
`endif

  assign new_work    = r_new_work;
  assign frame_error = r_frame_error;
  assign work_data   = r_work_data;

endmodule
`default_nettype wire

// File: tb/tb_work_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_work_receiver
// Description : Self-checking bench for work_receiver. Payloads are random or
//               fixed byte lists; expected words and checksums come from the
//               byte list itself (byte i lands at [639-8i -: 8]).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_work_receiver;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         new_work;
  logic [639:0] work_data;
  logic         frame_error;
  logic         rx_busy;

  int           n_vec = 0;
  int           n_err = 0;
  int           nw_total = 0;
  int           fe_total = 0;
  bit           chained = 1'b0;
  logic [639:0] model_wd = '0;
  logic [7:0]   payload [80];

  work_receiver #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (32'(TMO))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .new_work    (new_work),
    .work_data   (work_data),
    .frame_error (frame_error),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (new_work) nw_total++;
    if (frame_error) fe_total++;
    if (new_work || frame_error) begin
      n_vec++;
      if (new_work && frame_error) begin
        n_err++;
        $display("FAIL pulse_exclusive: new_work=%b frame_error=%b, required not both", new_work, frame_error);
      end
    end
  end

  function automatic logic [639:0] expected_word();
    logic [639:0] w = '0;
    for (int i = 0; i < 80; i++) w[639-8*i -: 8] = payload[i];
    return w;
  endfunction

  function automatic logic [7:0] expected_csum();
    logic [7:0] c = 8'h00;
    for (int i = 0; i < 80; i++) c = c ^ payload[i];
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Sends one frame from payload[]; long_gap_at puts TMO-1 idle cycles before
  // that byte, so the byte lands exactly on the would-be expiry cycle.
  task automatic send_frame(input string name, input int max_gap, input int long_gap_at,
                            input logic [7:0] csum_delta, input bit chain);
    logic [639:0] exp_w;
    bit           ok;
    int           nw0, fe0, g;
    nw0   = nw_total;
    fe0   = fe_total;
    exp_w = expected_word();
    if (!chained) send_byte(SYNC);
    for (int i = 0; i < 80; i++) begin
      g = (i == long_gap_at) ? TMO - 1 : ((i == 0) ? 0 : int'($urandom_range(max_gap, 0)));
      idle(g);
      @(negedge clk);
      if (i == 0) begin
        n_vec++;
        if (rx_busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy_in_frame: rx_busy=%b, required 1", name, rx_busy);
        end
      end
      rx_data  = payload[i];
      rx_valid = 1'b1;
    end
`ifdef WORK_RX_CHECKSUM_EN
    idle($urandom_range(max_gap, 0));
    send_byte(expected_csum() ^ csum_delta);
    ok = (csum_delta == 8'h00);
`else
    ok = 1'b1;
`endif
    @(negedge clk);
    n_vec++;
    if (new_work !== ok || frame_error !== !ok) begin
      n_err++;
      $display("FAIL %s outcome: new_work=%b frame_error=%b, required %b/%b", name, new_work, frame_error, ok, !ok);
    end
    if (ok) model_wd = exp_w;
    n_vec++;
    if (work_data !== model_wd) begin
      n_err++;
      $display("FAIL %s work_data: got %h required %h", name, work_data, model_wd);
    end
    n_vec++;
    if (rx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_end: rx_busy=%b, required 0", name, rx_busy);
    end
    n_vec++;
    if (nw_total - nw0 != int'(ok) || fe_total - fe0 != int'(!ok)) begin
      n_err++;
      $display("FAIL %s pulse_count: new_work x%0d frame_error x%0d, required %0d/%0d", name, nw_total - nw0, fe_total - fe0, ok, !ok);
    end
    if (chain) begin
      rx_data  = SYNC;
      rx_valid = 1'b1;
      chained  = 1'b1;
    end else begin
      rx_valid = 1'b0;
      chained  = 1'b0;
      @(negedge clk);
      n_vec++;
      if (new_work !== 1'b0 || frame_error !== 1'b0) begin
        n_err++;
        $display("FAIL %s pulse_width: new_work=%b frame_error=%b, required 0/0", name, new_work, frame_error);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_valid = ~rx_valid;
      rx_data  = (i % 3 == 0) ? SYNC : 8'($urandom);
      n_vec++;
      if ({new_work, frame_error, rx_busy} !== 3'b000 || work_data !== '0) begin
        n_err++;
        $display("FAIL reset_hold: nw/fe/busy=%b%b%b wd=%h, required all 0", new_work, frame_error, rx_busy, work_data);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b1;
    idle(3);
    n_vec++;
    if ({new_work, frame_error, rx_busy} !== 3'b000 || work_data !== '0) begin
      n_err++;
      $display("FAIL reset_release: nw/fe/busy=%b%b%b wd=%h, required all 0", new_work, frame_error, rx_busy, work_data);
    end
  endtask

  task automatic test_good_frame();
    for (int i = 0; i < 80; i++) payload[i] = 8'(i);
    send_frame("good_frame", 0, -1, 8'h00, 1'b0);
    n_vec++;
    if (work_data[639:632] !== 8'h00 || work_data[15:8] !== 8'h4E || work_data[7:0] !== 8'h4F) begin
      n_err++;
      $display("FAIL good_frame_bytes: [639:632]=%h [15:8]=%h [7:0]=%h, required 00 4e 4f",
               work_data[639:632], work_data[15:8], work_data[7:0]);
    end
  endtask

  task automatic test_garbage_then_frame();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h5A);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b = 8'($urandom);
      send_byte((b == SYNC) ? 8'h00 : b);
    end
    idle(1);
    for (int i = 0; i < 80; i++) payload[i] = 8'(i);
    send_frame("garbage_frame", 0, -1, 8'h00, 1'b0);
  endtask

  task automatic test_timeout();
    int fe0;
    fe0 = fe_total;
    send_byte(SYNC);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    @(negedge clk);
    rx_valid = 1'b0;
    for (int k = 1; k <= TMO + 1; k++) begin
      @(negedge clk);
      n_vec++;
      if (frame_error !== (k == TMO) || rx_busy !== (k < TMO)) begin
        n_err++;
        $display("FAIL timeout_idle%0d: frame_error=%b rx_busy=%b, required %b/%b", k, frame_error, rx_busy, k == TMO, k < TMO);
      end
    end
    n_vec++;
    if (work_data !== model_wd || fe_total - fe0 != 1 || new_work !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_result: wd=%h errors=%0d, required wd=%h errors=1", work_data, fe_total - fe0, model_wd);
    end
    chained = 1'b0;
    for (int i = 0; i < 80; i++) payload[i] = 8'($urandom);
    send_frame("timeout_extend", 0, 10, 8'h00, 1'b0);
  endtask

`ifdef WORK_RX_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < 80; i++) payload[i] = 8'(i);
    send_frame("csum_bad", 0, -1, 8'h01, 1'b0);
    for (int i = 0; i < 80; i++) payload[i] = 8'($urandom);
    send_frame("csum_bad_rand", 2, -1, 8'($urandom_range(255, 1)), 1'b0);
    for (int i = 0; i < 80; i++) payload[i] = 8'(i);
    send_frame("csum_good", 0, -1, 8'h00, 1'b0);
  endtask
`endif

  task automatic test_mid_frame_reset();
    send_byte(SYNC);
    for (int i = 0; i < 40; i++) send_byte(8'($urandom));
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b0;
    #1;
    model_wd = '0;
    n_vec++;
    if ({new_work, frame_error, rx_busy} !== 3'b000 || work_data !== '0) begin
      n_err++;
      $display("FAIL midreset_clear: nw/fe/busy=%b%b%b wd=%h, required all 0", new_work, frame_error, rx_busy, work_data);
    end
    @(negedge clk);
    rst     = 1'b1;
    chained = 1'b0;
    idle(2);
    for (int i = 0; i < 80; i++) payload[i] = 8'($urandom);
    send_frame("midreset_frame", 0, -1, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 5; f++) begin
      logic [7:0] delta;
      for (int i = 0; i < 80; i++) payload[i] = 8'($urandom);
      delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      send_frame($sformatf("b2b_%0d", f), 3, -1, delta, f != 4);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_garbage_then_frame();
    test_timeout();
`ifdef WORK_RX_CHECKSUM_EN
    test_checksum();
`endif
    test_mid_frame_reset();
    test_back_to_back();
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
